dna_read_arbiter: RTL and testbench

DNA_READ_ARBITER -- requirements
Module: dna_read_arbiter

---
 rtl/dna_read_arbiter_pkg.sv | 22 ++
 rtl/dna_read_arbiter_rr.sv | 43 ++++
 rtl/dna_read_arbiter.sv | 143 ++++++++++++++
 tb/tb_dna_read_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dna_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dna_read_arbiter_pkg
// Shared OptoHybrid control definitions used by the DNA read arbiter:
//   - dnaState_e : sequencer state encoding (IDLE, LOAD, SHIFT, DONE)
//   - cntWidth() : width of a counter that must hold the values 0..n
// No ports; imported by the arbiter top.
// ---------------------------------------------------------------------------
package dna_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } dnaState_e;

  // A counter that has to reach n itself needs clog2(n+1) bits.
  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dna_read_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector.
// Ports:
//   req_i        : request vector, one bit per requester
//   last_grant_i : one-hot of the requester served last; all-zero means
//                  nobody has been served yet, so the search starts at 0
//   grant_o      : one-hot grant (all-zero when no request is pending)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // The search begins one position past the last-served requester and wraps
  // around, so the requester just served is considered last. The outer loop
  // walks the search order; the inner loop picks the matching bit so every
  // select uses a plain loop index.
  always_comb begin
    int  startIdx;
    logic found;
    grant_o  = '0;
    startIdx = 0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_grant_i[i]) begin
        startIdx = (i + 1) % NUM_REQ;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == ((startIdx + k) % NUM_REQ)) && req_i[i]) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dna_read_arbiter.sv
// ---------------------------------------------------------------------------
// dna_read_arbiter
// Shares one DNA_PORT primitive between several requesters. A granted read
// pulses READ for one cycle, shifts the DNA out serially for DNA_LENGTH
// cycles, then publishes the value on dna and acknowledges the requester.
// Ports:
//   clock          : single clock; the parent also drives the primitive CLK
//   reset          : asynchronous, active-high
//   req            : level requests, held by each requester until its ack
//   ack            : one-cycle pulse to the served requester
//   dna            : last completed DNA value, MSB is the first bit out
//   dna_valid      : at least one read has completed since reset
//   busy           : a read is in progress (any state but IDLE)
//   dna_port_read  : primitive READ
//   dna_port_shift : primitive SHIFT, launched on the falling edge
//   dna_port_dout  : primitive DOUT (DIN is tied to DOUT by the parent)
// ---------------------------------------------------------------------------
module dna_read_arbiter
  import dna_read_arbiter_pkg::*;
#(
  parameter int DNA_LENGTH = 57,
  parameter int NUM_REQ    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DNA_LENGTH-1:0] dna,
  output logic                  dna_valid,
  output logic                  busy,
  output logic                  dna_port_read,
  output logic                  dna_port_shift,
  input  logic                  dna_port_dout
);

  localparam int               CNT_W    = cntWidth(DNA_LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DNA_LENGTH - 1);

  dnaState_e               state_q,     state_d;
  logic [NUM_REQ-1:0]      grant_q,     grant_d;
  logic [NUM_REQ-1:0]      lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]        bitCnt_q,    bitCnt_d;
  logic [DNA_LENGTH-1:0]   workReg_q,   workReg_d;
  logic [DNA_LENGTH-1:0]   dna_q,       dna_d;
  logic                    dnaValid_q,  dnaValid_d;
  logic [NUM_REQ-1:0]      ack_q,       ack_d;
  logic                    shift_q;
  logic [NUM_REQ-1:0]      rrGrant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i        (req),
    .last_grant_i (lastGrant_q),
    .grant_o      (rrGrant)
  );

  // Sequencer next-state and datapath. The grant is frozen when IDLE leaves,
  // so request changes during a read cannot disturb it. The working register
  // is only copied to dna in DONE, which keeps partial data off the output.
  // The ack is registered at the DONE edge, so it appears together with the
  // new dna value, and it is dropped if the requester has given up.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    bitCnt_d    = bitCnt_q;
    workReg_d   = workReg_q;
    dna_d       = dna_q;
    dnaValid_d  = dnaValid_q;
    ack_d       = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = rrGrant;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bitCnt_d  = '0;
        workReg_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        workReg_d = {workReg_q[DNA_LENGTH-2:0], dna_port_dout};
        bitCnt_d  = bitCnt_q + CNT_W'(1);
        if (bitCnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dna_d       = workReg_q;
        dnaValid_d  = 1'b1;
        ack_d       = grant_q & req;
        lastGrant_d = grant_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rising-edge state; reset aborts any read and clears all visible state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= '0;
      bitCnt_q    <= '0;
      workReg_q   <= '0;
      dna_q       <= '0;
      dnaValid_q  <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      bitCnt_q    <= bitCnt_d;
      workReg_q   <= workReg_d;
      dna_q       <= dna_d;
      dnaValid_q  <= dnaValid_d;
      ack_q       <= ack_d;
    end
  end

  // SHIFT to the primitive changes only on the falling edge, so it never
  // rises while clock is high. It is high for the rising edges that fall
  // inside the SHIFT state, one primitive shift per captured bit.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= 1'b0;
    end else begin
      shift_q <= (state_q == SHIFT);
    end
  end

  assign ack            = ack_q;
  assign dna            = dna_q;
  assign dna_valid      = dnaValid_q;
  assign busy           = (state_q != IDLE);
  assign dna_port_read  = (state_q == LOAD);
  assign dna_port_shift = shift_q;

endmodule

// File: tb/tb_dna_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dna_read_arbiter
// Self-checking bench for dna_read_arbiter with a behavioural DNA_PORT model.
// A transaction-level reference model predicts grants (round-robin by index
// arithmetic), ack timing and published dna from the request stream alone.
// ---------------------------------------------------------------------------
module tb_dna_read_arbiter;

  localparam int          LEN     = 57;
  localparam int          NREQ    = 2;
  localparam logic [56:0] SIM_DNA = 57'h123456789abcdef;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic [NREQ-1:0] ack;
  logic [LEN-1:0]  dna;
  logic            dna_valid;
  logic            busy;
  logic            dna_port_read;
  logic            dna_port_shift;
  logic            dna_port_dout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              cycle       = 0;
  bit              busyModel   = 0;
  int              startCycle  = 0;
  int              grantIdx    = 0;
  int              ptr         = 0;
  logic [LEN-1:0]  dnaExp      = '0;
  logic            validExp    = 1'b0;
  logic [NREQ-1:0] ackExpLast  = '0;
  logic [NREQ-1:0] lastAck     = '0;
  int              shiftEdges  = 0;

  dna_read_arbiter #(
    .DNA_LENGTH (LEN),
    .NUM_REQ    (NREQ)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .ack            (ack),
    .dna            (dna),
    .dna_valid      (dna_valid),
    .busy           (busy),
    .dna_port_read  (dna_port_read),
    .dna_port_shift (dna_port_shift),
    .dna_port_dout  (dna_port_dout)
  );

  always #5 clock = ~clock;

  // DNA_PORT behaviour: READ loads the fixed value, SHIFT moves it left with
  // DIN fed back from DOUT; READ wins over SHIFT.
  logic [56:0] dnaPrim = '0;
  always @(posedge clock) begin
    if (dna_port_read) dnaPrim <= SIM_DNA;
    else if (dna_port_shift) dnaPrim <= {dnaPrim[55:0], dnaPrim[56]};
  end
  assign dna_port_dout = dnaPrim[56];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // SHIFT must only ever rise while clock is low.
  always @(posedge dna_port_shift) begin
    checkOutput("shiftRiseClock", {63'b0, clock}, 64'd0);
  end

  // Drive one request pattern for one cycle, advance the reference model
  // across the rising edge, and compare every observable output.
  task automatic applyStimulus(input logic [NREQ-1:0] reqNext);
    logic [NREQ-1:0] ackExp;
    bit found;
    @(negedge clock);
    req = reqNext;
    @(posedge clock);
    cycle++;
    #1;
    ackExp = '0;
    if (dna_port_shift) shiftEdges++;
    if (busyModel) begin
      if (cycle == startCycle + LEN + 2) begin
        if (req[grantIdx]) ackExp[grantIdx] = 1'b1;
        dnaExp    = SIM_DNA;
        validExp  = 1'b1;
        ptr       = (grantIdx + 1) % NREQ;
        busyModel = 0;
        checkOutput("shiftEdgeCount", shiftEdges, LEN);
      end
    end else if (req != '0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (!found && req[i]) begin
          grantIdx = i;
          found    = 1;
        end
      end
      busyModel  = 1;
      startCycle = cycle;
      shiftEdges = 0;
    end
    checkOutput("ack", ack, ackExp);
    checkOutput("busy", busy, busyModel);
    checkOutput("read", dna_port_read, busyModel && (cycle == startCycle));
    checkOutput("dna", dna, dnaExp);
    checkOutput("dnaValid", dna_valid, validExp);
    ackExpLast = ackExp;
    lastAck    = ack;
  endtask

  // Assert reset between edges, check that outputs clear immediately, then
  // release on a falling edge with requests idle.
  task automatic applyReset();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rstAck", ack, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstRead", dna_port_read, 0);
    checkOutput("rstShift", dna_port_shift, 0);
    checkOutput("rstDna", dna, 0);
    checkOutput("rstValid", dna_valid, 0);
    busyModel  = 0;
    ptr        = 0;
    dnaExp     = '0;
    validExp   = 1'b0;
    ackExpLast = '0;
    shiftEdges = 0;
    @(negedge clock);
    req = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Hold a pattern from an idle start until an ack appears; the first edge
  // is the one at which IDLE samples the request.
  task automatic runUntilAck(input logic [NREQ-1:0] pat, input string tag,
                             output logic [NREQ-1:0] ackSeen);
    int sampleCycle;
    bit done;
    applyStimulus(pat);
    sampleCycle = cycle;
    done        = 0;
    ackSeen     = '0;
    for (int n = 0; n < 100 && !done; n++) begin
      applyStimulus(pat);
      if (lastAck != '0) begin
        done    = 1;
        ackSeen = lastAck;
        checkOutput({tag, "Latency"}, cycle - sampleCycle, LEN + 2);
      end
    end
    checkOutput({tag, "AckSeen"}, done, 1);
  endtask

  initial begin
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] seq [3];
    logic [NREQ-1:0] ackOr;
    logic [NREQ-1:0] reqHeld;
    int nAcks;

    applyReset();

    // Single requester 0
    runUntilAck(2'b01, "single", a);
    checkOutput("singleAck", a, 2'b01);
    checkOutput("singleDna", dna, SIM_DNA);
    checkOutput("singleValid", dna_valid, 1);

    // Both requesting continuously from reset: 0, 1, 0
    applyReset();
    seq   = '{default: '0};
    nAcks = 0;
    for (int n = 0; n < 300 && nAcks < 3; n++) begin
      applyStimulus(2'b11);
      if (lastAck != '0) begin
        seq[nAcks] = lastAck;
        nAcks++;
        checkOutput("rrDna", dna, SIM_DNA);
      end
    end
    checkOutput("rrCount", nAcks, 3);
    checkOutput("rrSeq0", seq[0], 2'b01);
    checkOutput("rrSeq1", seq[1], 2'b10);
    checkOutput("rrSeq2", seq[2], 2'b01);

    // Reset while shifting with bit counter at 20
    applyStimulus(2'b01);
    for (int n = 0; n < 21; n++) applyStimulus(2'b01);
    checkOutput("midBusy", busy, 1);
    applyReset();
    runUntilAck(2'b10, "postReset", a);
    checkOutput("postResetAck", a, 2'b10);
    checkOutput("postResetDna", dna, SIM_DNA);

    // Requester drops during SHIFT: read completes, ack discarded
    applyStimulus(2'b01);
    for (int n = 0; n < 10; n++) applyStimulus(2'b01);
    ackOr = '0;
    for (int n = 0; n < 70; n++) begin
      applyStimulus(2'b00);
      ackOr |= lastAck;
    end
    checkOutput("dropAck", ackOr, 0);
    checkOutput("dropDna", dna, SIM_DNA);
    checkOutput("dropValid", dna_valid, 1);
    checkOutput("dropBusy", busy, 0);

    // Randomised requesters that hold until acked, occasionally giving up
    reqHeld = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (reqHeld[i]) begin
          if (ackExpLast[i]) reqHeld[i] = 1'b0;
          else if ($urandom_range(299) == 0) reqHeld[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          reqHeld[i] = 1'b1;
        end
      end
      applyStimulus(reqHeld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
